// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM and its counters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_ctrl_pkg;

  // Stage encoding; the numeric values are visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

  // Decoded class flags: {is_link, is_br, is_st, is_ld, is_alu}.
  localparam int CLASS_W = 5;

  // Width of the MEM-state wait counter.
  localparam int WAIT_W = 8;

endpackage

// File: rtl/multicycle_ctrl_counters.sv
// Cycle, retire and MEM wait counters for the multi-cycle controller.
// Latency: counters update on the clock edge after the qualifying cycle.
// Backpressure: none; counts every qualifying cycle unconditionally.
module multicycle_ctrl_counters
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_retire,
  input  logic              i_in_mem,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_retire_cnt,
  output logic [WAIT_W-1:0] o_wait_cnt
);

  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycle_cnt <= '0;
    else       r_cycle_cnt <= r_cycle_cnt + 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retire_cnt <= '0;
    else if (i_retire) r_retire_cnt <= r_retire_cnt + 1'b1;
  end

  // Wait counter: zero on MEM entry, counts MEM cycles, saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_wait_cnt <= '0;
    else if (!i_in_mem)             r_wait_cnt <= '0;
    else if (r_wait_cnt != '1)      r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_retire_cnt = r_retire_cnt;
  assign o_wait_cnt   = r_wait_cnt;

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-stage (IF/ID/EXE/MEM/WB) sequencer for the multi-cycle datapath.
// Latency: 2 cycles (branch/illegal) to 4+ cycles plus SRAM wait states.
// Backpressure: stalls in IF until inst_ack and in MEM until data_ack or timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_ack,
  input  logic             data_ack,
  input  logic             is_alu,
  input  logic             is_ld,
  input  logic             is_st,
  input  logic             is_br,
  input  logic             is_link,
  input  logic             br_taken,
  output logic             inst_req,
  output logic             ir_we,
  output logic             data_req,
  output logic             data_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
  localparam logic              TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_illegal;
  logic               r_mem_timeout;
  logic [CLASS_W-1:0] w_cls;
  logic [WAIT_W-1:0]  w_wait_cnt;
  logic               w_timeout_hit;
  logic               w_set_illegal;
  logic               w_set_timeout;
  logic               w_inst_req, w_ir_we, w_data_req, w_data_we, w_mdr_we;
  logic               w_rf_we, w_pc_we, w_pc_sel, w_retire;

  assign w_cls         = {is_link, is_br, is_st, is_ld, is_alu};
  assign w_timeout_hit = TIMEOUT_EN && (w_wait_cnt == TIMEOUT_VAL);

  // State register; unknown encodings fall back to IF via next-state logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IF;
    else       r_state <= w_next_state;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal     <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_set_illegal) r_illegal     <= 1'b1;
      if (w_set_timeout) r_mem_timeout <= 1'b1;
    end
  end

  // Next-state and per-stage enable decode.
  always_comb begin
    w_next_state  = r_state;
    w_inst_req    = 1'b0;
    w_ir_we       = 1'b0;
    w_data_req    = 1'b0;
    w_data_we     = 1'b0;
    w_mdr_we      = 1'b0;
    w_rf_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_sel      = PC_SEL_SEQ;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_IF: begin
        w_inst_req = 1'b1;
        if (inst_ack) begin
          w_ir_we      = 1'b1;
          w_next_state = ST_ID;
        end
      end
      ST_ID: begin
        if (is_br) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = br_taken ? PC_SEL_BR : PC_SEL_SEQ;
          w_retire     = 1'b1;
          w_next_state = ST_IF;
        end else if (|w_cls) begin
          w_next_state = ST_EXE;
        end else begin
          // Undecodable: flag it and step over it like a nop.
          w_set_illegal = 1'b1;
          w_pc_we       = 1'b1;
          w_retire      = 1'b1;
          w_next_state  = ST_IF;
        end
      end
      ST_EXE: begin
        w_next_state = (is_ld || is_st) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        if (w_timeout_hit) begin
          // Abandon the access: advance PC without retiring.
          w_set_timeout = 1'b1;
          w_pc_we       = 1'b1;
          w_next_state  = ST_IF;
        end else begin
          w_data_req = 1'b1;
          w_data_we  = is_st;
          if (data_ack) begin
            if (is_st) begin
              w_pc_we      = 1'b1;
              w_retire     = 1'b1;
              w_next_state = ST_IF;
            end else begin
              w_mdr_we     = 1'b1;
              w_next_state = ST_WB;
            end
          end
        end
      end
      ST_WB: begin
        w_rf_we      = is_alu || is_ld || is_link;
        w_pc_we      = 1'b1;
        w_pc_sel     = (is_link && br_taken) ? PC_SEL_BR : PC_SEL_SEQ;
        w_retire     = 1'b1;
        w_next_state = ST_IF;
      end
      default: w_next_state = ST_IF;
    endcase
  end

  // Reset masks every strobe asynchronously so nothing leaks while held.
  assign inst_req    = w_inst_req & ~reset;
  assign ir_we       = w_ir_we    & ~reset;
  assign data_req    = w_data_req & ~reset;
  assign data_we     = w_data_we  & ~reset;
  assign mdr_we      = w_mdr_we   & ~reset;
  assign rf_we       = w_rf_we    & ~reset;
  assign pc_we       = w_pc_we    & ~reset;
  assign pc_sel      = w_pc_sel   & ~reset;
  assign retire      = w_retire   & ~reset;
  assign illegal     = r_illegal;
  assign mem_timeout = r_mem_timeout;
  assign state       = r_state;

  multicycle_ctrl_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk          (clk),
    .reset        (reset),
    .i_retire     (retire),
    .i_in_mem     (r_state == ST_MEM),
    .o_cycle_cnt  (cycle_cnt),
    .o_retire_cnt (retire_cnt),
    .o_wait_cnt   (w_wait_cnt)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table vectors, random instructions against a model,
// and hand sequences for reset behaviour.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_ack, data_ack;
  logic        is_alu, is_ld, is_st, is_br, is_link, br_taken;
  logic        inst_req, ir_we, data_req, data_we, mdr_we, rf_we, pc_we, pc_sel;
  logic        retire, illegal, mem_timeout;
  logic [2:0]  dut_state;
  logic [31:0] retire_cnt, cycle_cnt;

  multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .inst_ack(inst_ack), .data_ack(data_ack),
    .is_alu(is_alu), .is_ld(is_ld), .is_st(is_st), .is_br(is_br),
    .is_link(is_link), .br_taken(br_taken),
    .inst_req(inst_req), .ir_we(ir_we), .data_req(data_req), .data_we(data_we),
    .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .retire(retire), .illegal(illegal), .mem_timeout(mem_timeout),
    .state(dut_state), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles, ireq, dreq, dwe, rf, mdr, pcwe, pcsel, ret, ids, exes;
    int irwe, rf_bad, dwe_bad, conflict, cyc;
  } st_t;

  // Class bits: [0]=alu [1]=ld [2]=st [3]=br [4]=link
  typedef struct {
    logic [4:0] cls;
    logic       bt;
    int         iw, dw;
    int         e_cycles, e_ireq, e_dreq, e_rf, e_ret, e_pcsel;
  } vec_t;

  int checks = 0, failures = 0;
  int seq[$];
  int exp_ret = 0;
  bit exp_ill = 0, exp_to = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: cost and effects of one instruction from the stage rules.
  function automatic st_t model(input logic [4:0] c, input logic bt, input int iw,
                                input int dw, output bit ill, output bit to);
    st_t m = '{default: 0};
    ill = 0; to = 0;
    m.ireq = iw + 1; m.irwe = 1; m.ids = 1; m.pcwe = 1; m.cycles = iw + 2;
    if (c[3]) begin
      m.pcsel = int'(bt); m.ret = 1;
    end else if (c == 5'b0) begin
      ill = 1; m.ret = 1;
    end else begin
      m.exes = 1; m.cycles++;
      if (c[1] || c[2]) begin
        if (dw >= TO) begin
          to = 1; m.dreq = TO; m.dwe = c[2] ? TO : 0; m.cycles += TO + 1;
        end else begin
          m.dreq = dw + 1; m.cycles += dw + 1; m.ret = 1;
          if (c[2]) m.dwe = dw + 1;
          else begin m.mdr = 1; m.rf = 1; m.cycles++; end
        end
      end else begin
        m.rf = 1; m.ret = 1; m.cycles++;
        m.pcsel = c[4] ? int'(bt) : 0;
      end
    end
    m.cyc = m.cycles;
    return m;
  endfunction

  // Drives one instruction from IF until its PC update, collecting activity.
  task automatic run_instr(input logic [4:0] c, input logic bt, input int iw,
                           input int dw, output st_t s);
    int  if_n = 0, mem_n = 0;
    bit  done = 0;
    int  c0;
    s = '{default: 0};
    {is_link, is_br, is_st, is_ld, is_alu} = c;
    br_taken = bt;
    seq.delete();
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (k == 0) c0 = int'(cycle_cnt);
      inst_ack = (dut_state == 3'd0) && (if_n == iw);
      data_ack = (dut_state == 3'd3) && (mem_n == dw);
      #1;
      seq.push_back(int'(dut_state));
      s.cycles++;
      if (inst_req) s.ireq++;
      if (ir_we)    s.irwe++;
      if (data_req) s.dreq++;
      if (data_we)  s.dwe++;
      if (mdr_we)   s.mdr++;
      if (rf_we)    s.rf++;
      if (retire)   s.ret++;
      if (dut_state == 3'd1) s.ids++;
      if (dut_state == 3'd2) s.exes++;
      if (rf_we && dut_state != 3'd4) s.rf_bad++;
      if (data_we && dut_state != 3'd3) s.dwe_bad++;
      if ((rf_we && data_we) || (inst_req && data_req)) s.conflict++;
      if (dut_state == 3'd0) if_n++;
      if (dut_state == 3'd3) mem_n++;
      if (pc_we) begin
        s.pcwe++; s.pcsel = int'(pc_sel); done = 1;
      end
    end
    if (!done) chk("instr_cycle_budget", 0, 1);
    @(posedge clk);
    #1;
    inst_ack = 0; data_ack = 0;
    s.cyc = int'(cycle_cnt) - c0;
  endtask

  task automatic compare(input string tag, input st_t a, input st_t e);
    chk({tag, ".cycles"}, a.cycles, e.cycles);
    chk({tag, ".inst_req"}, a.ireq, e.ireq);
    chk({tag, ".ir_we"}, a.irwe, e.irwe);
    chk({tag, ".data_req"}, a.dreq, e.dreq);
    chk({tag, ".data_we"}, a.dwe, e.dwe);
    chk({tag, ".mdr_we"}, a.mdr, e.mdr);
    chk({tag, ".rf_we"}, a.rf, e.rf);
    chk({tag, ".pc_we"}, a.pcwe, e.pcwe);
    chk({tag, ".pc_sel"}, a.pcsel, e.pcsel);
    chk({tag, ".retire"}, a.ret, e.ret);
    chk({tag, ".id_cycles"}, a.ids, e.ids);
    chk({tag, ".exe_cycles"}, a.exes, e.exes);
    chk({tag, ".rf_outside_wb"}, a.rf_bad, 0);
    chk({tag, ".dwe_outside_mem"}, a.dwe_bad, 0);
    chk({tag, ".req_conflict"}, a.conflict, 0);
    chk({tag, ".cycle_cnt_delta"}, a.cyc, e.cyc);
  endtask

  task automatic exec_and_check(input string tag, input logic [4:0] c, input logic bt,
                                input int iw, input int dw, output st_t a);
    st_t e;
    bit  ill, to;
    e = model(c, bt, iw, dw, ill, to);
    run_instr(c, bt, iw, dw, a);
    compare(tag, a, e);
    exp_ret += e.ret;
    exp_ill |= ill;
    exp_to  |= to;
    chk({tag, ".retire_cnt"}, retire_cnt, exp_ret);
    chk({tag, ".illegal"}, illegal, exp_ill);
    chk({tag, ".mem_timeout"}, mem_timeout, exp_to);
  endtask

  vec_t tbl[9];

  initial begin
    st_t a;
    int  n;
    tbl[0] = '{5'b00001, 1'b0, 0, 0,    4, 1, 0, 1, 1, 0}; // alu, zero wait
    tbl[1] = '{5'b00010, 1'b0, 3, 2,   10, 4, 3, 1, 1, 0}; // ld, waits
    tbl[2] = '{5'b00100, 1'b0, 0, 0,    4, 1, 1, 0, 1, 0}; // st, zero wait
    tbl[3] = '{5'b01000, 1'b1, 0, 0,    2, 1, 0, 0, 1, 1}; // br taken
    tbl[4] = '{5'b01000, 1'b0, 1, 0,    3, 2, 0, 0, 1, 0}; // br not taken
    tbl[5] = '{5'b00000, 1'b0, 0, 0,    2, 1, 0, 0, 1, 0}; // illegal
    tbl[6] = '{5'b00100, 1'b0, 0, 1000, 8, 1, 4, 0, 0, 0}; // st timeout
    tbl[7] = '{5'b10000, 1'b1, 2, 0,    6, 3, 0, 1, 1, 1}; // link taken
    tbl[8] = '{5'b00010, 1'b0, 0, 3,    8, 1, 4, 1, 1, 0}; // ld, last legal ack

    reset = 1; inst_ack = 0; data_ack = 0;
    {is_link, is_br, is_st, is_ld, is_alu} = 5'b0; br_taken = 0;
    repeat (3) @(negedge clk);
    inst_ack = 1; data_ack = 1; is_st = 1;
    #1;
    chk("rst.state", dut_state, 0);
    chk("rst.inst_req", inst_req, 0);
    chk("rst.ir_we", ir_we, 0);
    chk("rst.pc_we", pc_we, 0);
    chk("rst.retire_cnt", retire_cnt, 0);
    chk("rst.cycle_cnt", cycle_cnt, 0);
    chk("rst.sticky", {illegal, mem_timeout}, 0);
    inst_ack = 0; data_ack = 0; is_st = 0;
    reset = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      exec_and_check(tag, tbl[i].cls, tbl[i].bt, tbl[i].iw, tbl[i].dw, a);
      chk({tag, ".tbl_cycles"}, a.cycles, tbl[i].e_cycles);
      chk({tag, ".tbl_inst_req"}, a.ireq, tbl[i].e_ireq);
      chk({tag, ".tbl_data_req"}, a.dreq, tbl[i].e_dreq);
      chk({tag, ".tbl_rf_we"}, a.rf, tbl[i].e_rf);
      chk({tag, ".tbl_retire"}, a.ret, tbl[i].e_ret);
      chk({tag, ".tbl_pc_sel"}, a.pcsel, tbl[i].e_pcsel);
      if (i == 0) begin
        chk("alu.seq_len", seq.size(), 4);
        if (seq.size() == 4) begin
          chk("alu.seq0", seq[0], 0);
          chk("alu.seq1", seq[1], 1);
          chk("alu.seq2", seq[2], 2);
          chk("alu.seq3", seq[3], 4);
        end
        chk("alu.back_to_if", dut_state, 0);
      end
    end

    for (int r = 0; r < 60; r++) begin
      int       k;
      logic [4:0] c;
      k = $urandom_range(0, 5);
      c = (k == 5) ? 5'b0 : 5'(1 << k);
      exec_and_check($sformatf("rnd%0d", r), c, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 5), a);
    end

    // Reset asserted while a load waits in MEM.
    {is_link, is_br, is_st, is_ld, is_alu} = 5'b00010;
    inst_ack = 1; data_ack = 0;
    n = 0;
    while (dut_state != 3'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midmem.reached_mem", dut_state, 3);
    @(negedge clk);
    #1;
    chk("midmem.data_req_before", data_req, 1);
    reset = 1;
    #1;
    chk("midmem.data_req_drop", data_req, 0);
    chk("midmem.data_we_drop", data_we, 0);
    chk("midmem.state", dut_state, 0);
    chk("midmem.retire_cnt", retire_cnt, 0);
    chk("midmem.sticky", {illegal, mem_timeout}, 0);
    @(negedge clk);
    reset = 0; inst_ack = 0;
    @(negedge clk);
    #1;
    chk("midmem.no_retire_after", retire_cnt, 0);
    chk("midmem.inst_req_after", inst_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
